// File: rtl/int_prio_ctrl_pkg.sv
// Shared types and defaults for the interrupt priority controller.
// Covers the state encoding, the default sizes and the spurious-vector offset.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    VECT = 2'd2
  } state_t;

  localparam int          N_DEF     = 4;
  localparam int          VW_DEF    = 8;
  localparam logic [7:0]  VBASE_DEF = 8'h20;
  // Spurious vector sits this many slots past the last real source.
  localparam int          SPUR_OFS  = 1;

endpackage

// File: rtl/int_prio_ctrl_if.sv
// Request/handshake bundle between the pending/enable registers, the CPU and
// the interrupt priority controller.
interface int_prio_ctrl_if
  import int_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int VW = VW_DEF
);

  logic [N-1:0]  req;
  logic [N-1:0]  en;
  logic          inta;
  logic          eoi;
  logic          int_o;
  logic [VW-1:0] vector;
  logic          vec_valid;
  logic [N-1:0]  ack_clr;
  logic [N-1:0]  in_service;

  modport master (
    output req, en, inta, eoi,
    input  int_o, vector, vec_valid, ack_clr, in_service
  );

  modport slave (
    input  req, en, inta, eoi,
    output int_o, vector, vec_valid, ack_clr, in_service
  );

endinterface

// File: rtl/int_prio_ctrl_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module prio_enc
  import int_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  in_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] idx_s;
  logic          vld_s;

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx_s = {IW{1'b0}};
    vld_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_s = in_i[i] ? IW'(i) : idx_s;
      vld_s = vld_s | in_i[i];
    end
  end

  assign idx_o   = idx_s;
  assign valid_o = vld_s;

endmodule

// File: rtl/int_prio_ctrl.sv
// Interrupt priority resolution and CPU acknowledge handshake.
// Optional nesting of higher-priority sources is enabled by INT_NESTING_EN.
module int_prio_ctrl
  import int_pkg::*;
#(
  parameter int              N     = N_DEF,
  parameter int              VW    = VW_DEF,
  parameter logic [VW-1:0]   VBASE = VW'(VBASE_DEF)
) (
  input  logic           clk,
  input  logic           clr,
  int_prio_ctrl_if.slave bus
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]  ONE_N    = N'(1'b1);
  localparam logic [VW-1:0] VEC_SPUR = VBASE + VW'(N - 1 + SPUR_OFS);

  state_t        state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic          spur_q, spur_d;
  logic          armed_q, armed_d;
  logic          int_q, int_d;
  logic [VW-1:0] vector_q, vector_d;
  logic          vv_q, vv_d;
  logic [N-1:0]  ack_clr_q, ack_clr_d;
  logic [N-1:0]  isr_q, isr_d;

  logic [N-1:0]  raw_s;
  logic [N-1:0]  elig_s;
  logic [IW-1:0] cand_idx_s;
  logic          cand_vld_s;
  logic [IW-1:0] eoi_idx_s;
  logic          eoi_vld_s;
  logic          ack_s;

  // Eligible set: enabled pending sources above the current in-service level.
`ifdef INT_NESTING_EN
  logic [N-1:0] isr_low_s;

  always_comb begin
    raw_s     = bus.req & bus.en & ~isr_q;
    isr_low_s = isr_q & (~isr_q + ONE_N);
    elig_s    = raw_s & (isr_low_s - ONE_N);
  end
`else
  always_comb begin
    raw_s = bus.req & bus.en & ~isr_q;
    if (isr_q == {N{1'b0}}) begin
      elig_s = raw_s;
    end else begin
      elig_s = {N{1'b0}};
    end
  end
`endif

  prio_enc #(.N(N), .IW(IW)) u_cand_enc (
    .in_i    (elig_s),
    .idx_o   (cand_idx_s),
    .valid_o (cand_vld_s)
  );

  prio_enc #(.N(N), .IW(IW)) u_eoi_enc (
    .in_i    (isr_q),
    .idx_o   (eoi_idx_s),
    .valid_o (eoi_vld_s)
  );

  // An acknowledge only counts once inta has been seen low since the last vector.
  assign ack_s = bus.inta & armed_q;

  // Next-state and registered-output logic for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    spur_d    = spur_q;
    int_d     = int_q;
    vector_d  = {VW{1'b0}};
    vv_d      = 1'b0;
    ack_clr_d = {N{1'b0}};
    isr_d     = isr_q;
    armed_d   = (state_q == VECT) ? 1'b0 : (armed_q | ~bus.inta);

    if (bus.eoi && eoi_vld_s) begin
      isr_d[eoi_idx_s] = 1'b0;
    end else begin
      isr_d = isr_q;
    end

    case (state_q)
      IDLE: begin
        if (cand_vld_s) begin
          state_d = PEND;
          sel_d   = cand_idx_s;
          int_d   = 1'b1;
        end else begin
          int_d   = 1'b0;
        end
      end
      PEND: begin
        if (ack_s) begin
          state_d = VECT;
          spur_d  = ~cand_vld_s;
          int_d   = 1'b1;
        end else if (cand_vld_s) begin
          sel_d   = cand_idx_s;
          int_d   = 1'b1;
        end else begin
          state_d = IDLE;
          int_d   = 1'b0;
        end
      end
      VECT: begin
        state_d = IDLE;
        int_d   = 1'b0;
        vv_d    = 1'b1;
        if (spur_q) begin
          vector_d = VEC_SPUR;
        end else begin
          vector_d      = VBASE + VW'(sel_q);
          ack_clr_d     = ONE_N << sel_q;
          isr_d[sel_q]  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      sel_q     <= {IW{1'b0}};
      spur_q    <= 1'b0;
      armed_q   <= 1'b0;
      int_q     <= 1'b0;
      vector_q  <= {VW{1'b0}};
      vv_q      <= 1'b0;
      ack_clr_q <= {N{1'b0}};
      isr_q     <= {N{1'b0}};
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      spur_q    <= spur_d;
      armed_q   <= armed_d;
      int_q     <= int_d;
      vector_q  <= vector_d;
      vv_q      <= vv_d;
      ack_clr_q <= ack_clr_d;
      isr_q     <= isr_d;
    end
  end

  assign bus.int_o      = int_q;
  assign bus.vector     = vector_q;
  assign bus.vec_valid  = vv_q;
  assign bus.ack_clr    = ack_clr_q;
  assign bus.in_service = isr_q;

endmodule

// File: tb/tb_int_prio_ctrl.sv
// Directed self-checking bench for int_prio_ctrl (N=4, VW=8, VBASE=8'h20).
module tb_int_prio_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int_prio_ctrl_if #(.N(4), .VW(8)) bus ();

  int_prio_ctrl #(.N(4), .VW(8), .VBASE(8'h20)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1;
    step(1);
    bus.eoi = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req  = 4'b0000;
    bus.en   = 4'b0000;
    bus.inta = 1'b0;
    bus.eoi  = 1'b0;
    step(2);
    chk("rst_int",  32'(bus.int_o),      32'h0);
    chk("rst_vv",   32'(bus.vec_valid),  32'h0);
    chk("rst_vec",  32'(bus.vector),     32'h0);
    chk("rst_ack",  32'(bus.ack_clr),    32'h0);
    chk("rst_isr",  32'(bus.in_service), 32'h0);
    clr = 1'b1;
    step(1);

    // Single request on source 2
    bus.en  = 4'b1111;
    bus.req = 4'b0100;
    step(1);
    chk("t1_int",   32'(bus.int_o), 32'h1);
    bus.inta = 1'b1;
    step(1);
    chk("t1_int_vect", 32'(bus.int_o),     32'h1);
    chk("t1_vv_early", 32'(bus.vec_valid), 32'h0);
    step(1);
    chk("t1_vv",    32'(bus.vec_valid),  32'h1);
    chk("t1_vec",   32'(bus.vector),     32'h22);
    chk("t1_ack",   32'(bus.ack_clr),    32'h4);
    chk("t1_isr",   32'(bus.in_service), 32'h4);
    chk("t1_int_fall", 32'(bus.int_o),   32'h0);
    bus.req  = 4'b0000;
    bus.inta = 1'b0;
    step(1);
    chk("t1_vv_one", 32'(bus.vec_valid), 32'h0);
    chk("t1_ack_one", 32'(bus.ack_clr),  32'h0);
    pulse_eoi();
    chk("t1_eoi",   32'(bus.in_service), 32'h0);

    // Preemption while pending
    bus.req = 4'b1000;
    step(1);
    chk("t2_int",   32'(bus.int_o), 32'h1);
    bus.req = 4'b1001;
    step(1);
    bus.inta = 1'b1;
    step(2);
    chk("t2_vec",   32'(bus.vector),     32'h20);
    chk("t2_ack",   32'(bus.ack_clr),    32'h1);
    chk("t2_isr",   32'(bus.in_service), 32'h1);
    bus.req  = 4'b1000;
    bus.inta = 1'b0;
    step(2);
    chk("t2_lowblk", 32'(bus.int_o), 32'h0);
    pulse_eoi();
    chk("t2_eoi",   32'(bus.in_service), 32'h0);
    step(1);
    chk("t2_int3",  32'(bus.int_o), 32'h1);
    bus.req = 4'b0000;
    step(1);
    chk("t2_empty", 32'(bus.int_o), 32'h0);

    // Spurious acknowledge, then inta held high
    bus.req = 4'b0010;
    step(1);
    chk("t3_int",   32'(bus.int_o), 32'h1);
    bus.req  = 4'b0000;
    bus.inta = 1'b1;
    step(2);
    chk("t3_vv",    32'(bus.vec_valid),  32'h1);
    chk("t3_vec",   32'(bus.vector),     32'h24);
    chk("t3_ack",   32'(bus.ack_clr),    32'h0);
    chk("t3_isr",   32'(bus.in_service), 32'h0);
    bus.req = 4'b0100;
    step(1);
    chk("t3_int2",  32'(bus.int_o),     32'h1);
    chk("t3_hold1", 32'(bus.vec_valid), 32'h0);
    step(1);
    chk("t3_hold2", 32'(bus.vec_valid), 32'h0);
    step(1);
    chk("t3_hold3", 32'(bus.vec_valid), 32'h0);
    bus.inta = 1'b0;
    step(1);
    bus.inta = 1'b1;
    step(2);
    chk("t3_revv",  32'(bus.vec_valid), 32'h1);
    chk("t3_revec", 32'(bus.vector),    32'h22);
    bus.req  = 4'b0000;
    bus.inta = 1'b0;
    pulse_eoi();
    chk("t3_eoi",   32'(bus.in_service), 32'h0);

    // Masking and priority
    bus.en  = 4'b1110;
    bus.req = 4'b0011;
    step(1);
    chk("t4_int",   32'(bus.int_o), 32'h1);
    bus.inta = 1'b1;
    step(2);
    chk("t4_vec",   32'(bus.vector),     32'h21);
    chk("t4_ack",   32'(bus.ack_clr),    32'h2);
    chk("t4_isr",   32'(bus.in_service), 32'h2);
    bus.inta = 1'b0;
    bus.req  = 4'b1001;
    step(2);
    chk("t4_blk",   32'(bus.int_o), 32'h0);
    pulse_eoi();
    chk("t4_eoi",   32'(bus.in_service), 32'h0);
    step(1);
    chk("t4_int3",  32'(bus.int_o), 32'h1);
    bus.req = 4'b0000;
    bus.en  = 4'b1111;
    step(1);
    chk("t4_idle",  32'(bus.int_o), 32'h0);

    // Nesting behaviour with source 2 in service
    bus.req = 4'b0100;
    step(1);
    chk("t5_int",   32'(bus.int_o), 32'h1);
    bus.inta = 1'b1;
    step(2);
    chk("t5_isr",   32'(bus.in_service), 32'h4);
    bus.inta = 1'b0;
    bus.req  = 4'b0010;
`ifdef INT_NESTING_EN
    step(1);
    chk("t5_nest_int", 32'(bus.int_o), 32'h1);
    bus.inta = 1'b1;
    step(2);
    chk("t5_nest_vec", 32'(bus.vector),     32'h21);
    chk("t5_nest_isr", 32'(bus.in_service), 32'h6);
    bus.inta = 1'b0;
    bus.req  = 4'b0000;
    pulse_eoi();
    chk("t5_nest_eoi1", 32'(bus.in_service), 32'h4);
    pulse_eoi();
    chk("t5_nest_eoi2", 32'(bus.in_service), 32'h0);
`else
    step(2);
    chk("t5_held",  32'(bus.int_o), 32'h0);
    pulse_eoi();
    chk("t5_eoi",   32'(bus.in_service), 32'h0);
    step(1);
    chk("t5_int2",  32'(bus.int_o), 32'h1);
    bus.inta = 1'b1;
    step(2);
    chk("t5_vec",   32'(bus.vector),     32'h21);
    chk("t5_isr2",  32'(bus.in_service), 32'h2);
    bus.inta = 1'b0;
    bus.req  = 4'b0000;
    pulse_eoi();
    chk("t5_eoi2",  32'(bus.in_service), 32'h0);
`endif

    // Reset during PEND, then during VECT with inta held
    bus.req = 4'b0100;
    step(1);
    chk("t6_int",   32'(bus.int_o), 32'h1);
    clr = 1'b0;
    #1;
    chk("t6_rst_int", 32'(bus.int_o),      32'h0);
    chk("t6_rst_vv",  32'(bus.vec_valid),  32'h0);
    step(1);
    clr = 1'b1;
    step(1);
    chk("t6_int2",  32'(bus.int_o), 32'h1);
    bus.inta = 1'b1;
    step(1);
    clr = 1'b0;
    #1;
    chk("t6_rst2_int", 32'(bus.int_o),     32'h0);
    chk("t6_rst2_vv",  32'(bus.vec_valid), 32'h0);
    step(1);
    chk("t6_rst2_vv2", 32'(bus.vec_valid), 32'h0);
    clr = 1'b1;
    step(1);
    chk("t6_int3",  32'(bus.int_o),     32'h1);
    chk("t6_novv1", 32'(bus.vec_valid), 32'h0);
    step(1);
    chk("t6_novv2", 32'(bus.vec_valid),  32'h0);
    chk("t6_isr",   32'(bus.in_service), 32'h0);
    bus.inta = 1'b0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_prio_ctrl.md
# int_prio_ctrl

Priority resolution and CPU handshake stage of the interrupt system. It sits directly downstream of the pending-request and enable registers (ld_st_reg instances) and consumes their outputs. It selects the highest-priority enabled pending request, raises the CPU interrupt line and serves the vector on acknowledge. It also pulses a one-hot clear back to the pending register and tracks in-service levels until end-of-interrupt.

## Interface
- N, 4: number of interrupt sources; bit 0 is highest priority
- VW, 8: vector width in bits
- VBASE, 8'h20: vector of source 0; source i gets VBASE+i, spurious gets VBASE+N
---
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- req  in  N  pending requests from the pending register
- en  in  N  enable mask from the enable register, 1 = enabled
- inta  in  1  CPU interrupt acknowledge, level, sampled on clk
- eoi  in  1  end-of-interrupt strobe, one cycle
- int_o  out  1  interrupt request to CPU
- vector  out  VW  vector, valid only while vec_valid=1
- vec_valid  out  1  one-cycle vector strobe
- ack_clr  out  N  one-hot, one-cycle clear pulse to the pending register
- in_service  out  N  in-service levels

## Operation
- Eligible set: E = req & en & ~in_service, restricted to bits of higher priority (lower index) than the lowest set in_service bit. When in_service = 0, all of E is eligible.
- Candidate: the lowest index in the eligible set.
- State machine IDLE, PEND, VECT; all outputs registered.
- IDLE
  - Candidate exists → PEND; latch sel = candidate; int_o = 1.
  - inta while in IDLE is ignored.
- PEND
  - While inta = 0, re-evaluate sel every cycle, so a higher-priority arrival preempts.
  - Eligible set empties → IDLE; int_o = 0.
  - inta = 1 → VECT.
- VECT (one cycle)
  - int_o = 0; vec_valid = 1; vector = VBASE + sel; ack_clr[sel] = 1; in_service[sel] set; next state IDLE.
  - Spurious acknowledge: if the eligible set was empty at the inta sample, vector = VBASE + N, ack_clr = 0 and in_service is unchanged.
- eoi clears the lowest-index set in_service bit. eoi with in_service = 0 is ignored.
- eoi in the same cycle as VECT: the clear applies to the pre-update value, then the set applies.
- N ≤ 2^VW − VBASE − 1 is a stated constraint; it is not checked.

## Timing
- Reset values: state IDLE, int_o 0, vector 0, vec_valid 0, ack_clr 0, in_service 0. Reset is effective immediately and also applies mid-handshake.
- req/en change visible at edge t → int_o = 1 after edge t+1.
- inta sampled high at edge t → vec_valid, vector and ack_clr high after edge t+1, for exactly one cycle.
- int_o falls on the same edge that vec_valid rises.
- Back-to-back: a new int_o is raised no earlier than the cycle after vec_valid.
- inta held high through VECT and IDLE does not produce a second vector. A new vector requires inta low, then high again, while in PEND.

## Configuration
- INT_NESTING_EN defined:
  - in_service may hold several bits.
  - A strictly higher-priority source may interrupt while a lower level is in service.
- INT_NESTING_EN undefined:
  - The eligible set is empty whenever in_service ≠ 0, so at most one bit is ever set.
  - No new int_o is raised until eoi.

## Structure
- Package int_pkg holds:
  - state encoding typedef (IDLE, PEND, VECT)
  - default VBASE
  - helper localparam for the spurious offset
- One sub-module, prio_enc: N-bit lowest-index-first priority encoder with a valid output.
  - Instantiated twice: candidate selection and eoi clear selection.

## Test plan
- Single request: N=4, en=4'b1111, req=4'b0100 → int_o after 1 cycle; inta → vector 8'h22, ack_clr 4'b0100, in_service 4'b0100.
- Preemption in PEND: req=4'b1000, then req=4'b1001 before inta → vector 8'h20, ack_clr 4'b0001.
- Spurious acknowledge: int_o raised for req=4'b0010, req drops to 0 the cycle before inta → vector 8'h24, ack_clr 0, in_service 0.
- Nesting:
  - With INT_NESTING_EN: in_service=4'b0100; req bit 1 → serviced, in_service=4'b0110; eoi → 4'b0100.
  - Without INT_NESTING_EN: req bit 1 is held off until eoi.
- Masking and priority: en=4'b1110, req=4'b0011 → vector 8'h21; req bit 3 with in_service=4'b0010 → no int_o.
- Reset mid-handshake: clr low during PEND → int_o, vec_valid and in_service 0 immediately; no vector after release.
